// File: rtl/bist_seq_ctrl.sv
// Multi-channel BIST sequencer: walks the enabled channels through INIT/RUN/FINISH,
// compares each channel's signature against its golden value and reports pass/fail.
module bist_seq_ctrl #(
    parameter int N_CHAN = 4,
    parameter int CNT_W  = 8,
    parameter int SIG_W  = 16,
    localparam int CH_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        run_len,
    input  logic [N_CHAN-1:0]       chan_mask,
    input  logic [N_CHAN*SIG_W-1:0] sig_in,
    input  logic [N_CHAN*SIG_W-1:0] golden,
    output logic                    init,
    output logic                    running,
    output logic                    toggle,
    output logic                    finish,
    output logic                    bist_end,
    output logic                    busy,
    output logic [CH_W-1:0]         chan_sel,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [N_CHAN-1:0]       fail_vec,
    output logic                    pass,
    output logic                    aborted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [N_CHAN-1:0]  mask_q, mask_d;
    logic [CH_W-1:0]    chan_q, chan_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CHAN-1:0]  fail_q, fail_d;
    logic               pass_q, pass_d;
    logic               aborted_q, aborted_d;

    logic [CH_W-1:0]    first_chan;
    logic [CH_W-1:0]    next_chan;
    logic               has_next;
    logic [SIG_W-1:0]   sig_sel;
    logic [SIG_W-1:0]   gold_sel;

    // Descending scan so the last hit is the lowest qualifying channel.
    always_comb begin
        first_chan = '0;
        next_chan  = '0;
        has_next   = 1'b0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_chan = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(chan_q))) begin
                next_chan = CH_W'(i);
                has_next  = 1'b1;
            end
        end
    end

    assign sig_sel  = sig_in[int'(chan_q) * SIG_W +: SIG_W];
    assign gold_sel = golden[int'(chan_q) * SIG_W +: SIG_W];

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        mask_d    = mask_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        fail_d    = fail_q;
        pass_d    = pass_q;
        aborted_d = aborted_q;

        if ((state_q != S_IDLE) && abort) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            pass_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        len_d     = (run_len == '0) ? CNT_W'(1) : run_len;
                        mask_d    = chan_mask;
                        fail_d    = '0;
                        pass_d    = 1'b0;
                        aborted_d = 1'b0;
                        if (chan_mask == '0) begin
                            chan_d  = '0;
                            pass_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            chan_d  = first_chan;
                            state_d = S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    // Counter holds at L-1 through FINISH rather than wrapping.
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = S_FINISH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    if (sig_sel != gold_sel) begin
                        fail_d[chan_q] = 1'b1;
                    end
                    if (has_next) begin
                        chan_d  = next_chan;
                        state_d = S_INIT;
                    end else begin
                        pass_d  = (fail_d == '0);
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            mask_q    <= '0;
            chan_q    <= '0;
            cnt_q     <= '0;
            fail_q    <= '0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            mask_q    <= mask_d;
            chan_q    <= chan_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            pass_q    <= pass_d;
            aborted_q <= aborted_d;
        end
    end

    assign init      = (state_q == S_INIT);
    assign running   = (state_q == S_RUN);
    assign toggle    = (state_q == S_RUN) && cnt_q[0];
    assign finish    = (state_q == S_FINISH);
    assign bist_end  = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign chan_sel  = chan_q;
    assign cycle_cnt = cnt_q;
    assign fail_vec  = fail_q;
    assign pass      = pass_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Directed bench for bist_seq_ctrl: a per-cycle vector table for the nominal
// single-channel session plus hand-written multi-cycle corner-case sequences.
module tb_bist_seq_ctrl;

    localparam int N_CHAN = 4;
    localparam int CNT_W  = 8;
    localparam int SIG_W  = 16;
    localparam int CH_W   = 2;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        run_len;
    logic [N_CHAN-1:0]       chan_mask;
    logic [N_CHAN*SIG_W-1:0] sig_in;
    logic [N_CHAN*SIG_W-1:0] golden;
    logic                    init;
    logic                    running;
    logic                    toggle;
    logic                    finish;
    logic                    bist_end;
    logic                    busy;
    logic [CH_W-1:0]         chan_sel;
    logic [CNT_W-1:0]        cycle_cnt;
    logic [N_CHAN-1:0]       fail_vec;
    logic                    pass;
    logic                    aborted;

    bist_seq_ctrl #(
        .N_CHAN(N_CHAN),
        .CNT_W (CNT_W),
        .SIG_W (SIG_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .run_len  (run_len),
        .chan_mask(chan_mask),
        .sig_in   (sig_in),
        .golden   (golden),
        .init     (init),
        .running  (running),
        .toggle   (toggle),
        .finish   (finish),
        .bist_end (bist_end),
        .busy     (busy),
        .chan_sel (chan_sel),
        .cycle_cnt(cycle_cnt),
        .fail_vec (fail_vec),
        .pass     (pass),
        .aborted  (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic       start;
        logic [5:0] flags;   // {init, running, toggle, finish, bist_end, busy}
        logic [7:0] cnt;
        logic       pass;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulses start across edge 0; on return we are inside cycle 1.
    task automatic start_session(input logic [7:0] len, input logic [3:0] m);
        run_len   = len;
        chan_mask = m;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic run_to_idle(output int end_at, output int n_run);
        bit done;
        end_at = -1;
        n_run  = 0;
        done   = 0;
        for (int k = 0; k < 300; k++) begin
            if (!busy) begin
                done = 1;
                break;
            end
            if (bist_end) end_at = cyc;
            if (running) n_run++;
            tick();
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL session_timeout: busy still high after 300 cycles");
        end
    endtask

    initial begin
        int e;
        int nr;
        bit seen_end;

        tbl[0] = '{1'b1, 6'b100001, 8'd0, 1'b0};
        tbl[1] = '{1'b0, 6'b010001, 8'd0, 1'b0};
        tbl[2] = '{1'b0, 6'b011001, 8'd1, 1'b0};
        tbl[3] = '{1'b0, 6'b010001, 8'd2, 1'b0};
        tbl[4] = '{1'b0, 6'b011001, 8'd3, 1'b0};
        tbl[5] = '{1'b0, 6'b010001, 8'd4, 1'b0};
        tbl[6] = '{1'b0, 6'b000101, 8'd4, 1'b0};
        tbl[7] = '{1'b0, 6'b000011, 8'd4, 1'b1};
        tbl[8] = '{1'b0, 6'b000000, 8'd4, 1'b1};

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        run_len   = 8'd5;
        chan_mask = 4'b0001;
        golden    = 64'h1234_5678_9ABC_DEF0;
        sig_in    = golden;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_vec", fail_vec, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        reset = 1'b0;
        tick();

        // Nominal session: run_len=5, single channel, matching signature.
        run_len   = 8'd5;
        chan_mask = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            start = tbl[k].start;
            tick();
            start = 1'b0;
            chk($sformatf("tbl%0d_flags", k), {init, running, toggle, finish, bist_end, busy}, tbl[k].flags);
            chk($sformatf("tbl%0d_cnt", k), cycle_cnt, tbl[k].cnt);
            chk($sformatf("tbl%0d_pass", k), pass, tbl[k].pass);
        end
        chk("tbl_fail_vec", fail_vec, 0);

        // Two channels (1 and 3), channel 3 mismatched, run_len=3.
        sig_in = golden ^ (64'h1 << 48);
        start_session(8'd3, 4'b1010);
        while (cyc < 12) begin
            if (cyc == 1)  chk("s2_chan_first", chan_sel, 1);
            if (cyc == 6)  chk("s2_chan_second", chan_sel, 3);
            if (cyc == 10) chk("s2_finish", finish, 1);
            if (cyc == 10) chk("s2_fail_before", fail_vec, 0);
            if (cyc == 11) begin
                chk("s2_bist_end", bist_end, 1);
                chk("s2_fail_vec", fail_vec, 4'b1000);
                chk("s2_pass", pass, 0);
            end
            tick();
        end
        chk("s2_idle", busy, 0);
        sig_in = golden;

        // run_len=0 behaves as a single RUN cycle.
        start_session(8'd0, 4'b0001);
        run_to_idle(e, nr);
        chk("len0_end_cycle", e, 4);
        chk("len0_run_cycles", nr, 1);
        chk("len0_pass", pass, 1);

        // Empty mask goes straight to DONE.
        start_session(8'd7, 4'b0000);
        chk("mask0_bist_end", bist_end, 1);
        chk("mask0_pass", pass, 1);
        tick();
        chk("mask0_idle", busy, 0);

        // Abort in cycle 4 of a run_len=5 session.
        seen_end = 0;
        start_session(8'd5, 4'b0001);
        while (cyc < 4) begin
            seen_end |= bist_end;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_flag", aborted, 1);
        chk("abort_pass", pass, 0);
        repeat (5) begin
            seen_end |= bist_end;
            tick();
        end
        chk("abort_no_end", seen_end, 0);
        start_session(8'd2, 4'b0001);
        chk("abort_cleared", aborted, 0);
        run_to_idle(e, nr);
        chk("post_abort_end", e, 5);

        // Start pulsed mid-RUN must not disturb the timeline.
        e = -1;
        start_session(8'd5, 4'b0001);
        while (busy && cyc < 50) begin
            start = (cyc == 3);
            if (bist_end) e = cyc;
            tick();
        end
        start = 1'b0;
        chk("busy_start_end", e, 8);
        chk("busy_start_idle_cycle", cyc, 9);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("collide_busy", busy, 0);
        tick();
        chk("collide_busy2", busy, 0);
        chk("collide_aborted", aborted, 0);

        // Asynchronous reset mid-RUN of channel 1, after channel 0 failed.
        sig_in = golden ^ 64'h1;
        start_session(8'd5, 4'b1111);
        while (cyc < 10) tick();
        chk("pre_rst_fail_vec", fail_vec, 4'b0001);
        chk("pre_rst_running", running, 1);
        chk("pre_rst_chan", chan_sel, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_outputs",
            {init, running, toggle, finish, bist_end, busy, pass, aborted}, 0);
        chk("arst_chan_sel", chan_sel, 0);
        chk("arst_cycle_cnt", cycle_cnt, 0);
        chk("arst_fail_vec", fail_vec, 0);
        @(negedge clk);
        reset  = 1'b0;
        sig_in = golden;
        tick();
        start_session(8'd5, 4'b0001);
        run_to_idle(e, nr);
        chk("post_rst_end", e, 8);
        chk("post_rst_run_cycles", nr, 5);
        chk("post_rst_pass", pass, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_seq_ctrl.md
# bist_seq_ctrl

Parametrised multi-channel BIST sequencer. It runs a programmable-length test pass on each enabled channel in turn, then compares each channel's signature against a golden value. It reports a per-channel fail vector and an overall pass flag. It sits between the top-level test access logic and the per-channel pattern generators and MISRs, and drives their init/run/toggle/finish controls.

## Interface
- `N_CHAN`, 4: number of channels under test (1..16).
- `CNT_W`, 8: width of the run-length and cycle counters.
- `SIG_W`, 16: width of one channel signature.
- `CH_W`, max(1, clog2(N_CHAN)), localparam: channel index width.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE only.
- `abort`  in  1  level; terminates any session.
- `run_len`  in  CNT_W  RUN cycles per channel; latched at start.
- `chan_mask`  in  N_CHAN  channel enables; latched at start.
- `sig_in`  in  N_CHAN*SIG_W  channel signatures; channel i is at [i*SIG_W +: SIG_W].
- `golden`  in  N_CHAN*SIG_W  expected signatures, same packing as `sig_in`.
- `init`  out  1  high during INIT.
- `running`  out  1  high during RUN.
- `toggle`  out  1  pattern toggle; equals cycle_cnt[0] in RUN, 0 elsewhere.
- `finish`  out  1  high during FINISH.
- `bist_end`  out  1  one-cycle pulse in DONE.
- `busy`  out  1  high in every state except IDLE.
- `chan_sel`  out  CH_W  index of the channel under test.
- `cycle_cnt`  out  CNT_W  RUN cycle index 0..L-1.
- `fail_vec`  out  N_CHAN  sticky per-channel mismatch flags.
- `pass`  out  1  registered; 1 only after a complete session with fail_vec==0.
- `aborted`  out  1  sticky; set by abort, cleared by the next accepted start.

## Operation
- States: IDLE, INIT, RUN, FINISH, DONE.
- Effective run length: L = run_len; a run_len of 0 is treated as L=1.
- **IDLE**, start=1, abort=0:
  - Latch L and chan_mask.
  - Clear fail_vec, pass and aborted.
  - If chan_mask==0: go to DONE, and pass=1 in DONE.
  - Otherwise: chan_sel = lowest set mask bit, go to INIT.
- **INIT**: clears cycle_cnt; next state RUN.
- **RUN**:
  - cycle_cnt increments every cycle.
  - On the cycle where cycle_cnt==L-1, next state is FINISH.
  - cycle_cnt saturates at L-1 and never wraps within RUN.
- **FINISH**:
  - Compare the sig_in slice of chan_sel against its golden slice.
  - On mismatch, set fail_vec[chan_sel].
  - If a higher enabled channel remains: chan_sel = next set bit, go to INIT.
  - Otherwise: go to DONE.
- **DONE**: bist_end=1 for one cycle; pass = (fail_vec==0); next state IDLE.
- Results persist: fail_vec, pass and aborted hold until the next accepted start or reset.
- **abort=1 in any non-IDLE state**:
  - Next state IDLE; aborted=1, pass=0.
  - bist_end does not pulse.
  - fail_vec keeps the partial results.
- **abort in IDLE**: ignored. If start and abort are both high in IDLE, abort wins and start is not accepted.
- **start while busy**: ignored; it does not restart the session.
- **Masked channels**: never selected and never flagged.

## Timing
- **Reset**: asynchronous assertion forces state IDLE. All outputs go to 0 on assertion, including fail_vec, pass, aborted, chan_sel and cycle_cnt. Release is synchronous to clk.
- **Session timeline**: start is sampled high at edge 0.
  - INIT occupies cycle 1.
  - Channel m (0-based among enabled channels) occupies cycles 1+m(L+2) .. (m+1)(L+2).
  - Within each channel: 1 INIT cycle, L RUN cycles, 1 FINISH cycle.
  - With M enabled channels, DONE (bist_end) falls in cycle 1+M(L+2); busy drops the cycle after that.
- **Empty mask**: DONE in cycle 1.
- **Compare sampling**: sig_in and golden are sampled on the clock edge that ends the FINISH cycle. fail_vec updates in the following cycle.
- **Output encoding**: all outputs are decoded from registered state and counters. There are no combinational paths from the inputs to the outputs.
- **abort latency**: abort is sampled at edge n; the state is IDLE in cycle n+1.
- **Reset mid-session**: immediate return to IDLE with all results cleared.

## Test plan
- N_CHAN=4, run_len=5, mask=4'b0001, sig==golden:
  - init in cycle 1; running in cycles 2-6, with toggle 0,1,0,1,0; finish in cycle 7.
  - bist_end in cycle 8, pass=1, fail_vec=0.
- mask=4'b1010, run_len=3, channel 3 signature mismatched:
  - chan_sel=1, then 3; bist_end in cycle 11.
  - fail_vec=4'b1000, pass=0.
- Edge cases:
  - run_len=0, mask=4'b0001: exactly one RUN cycle; bist_end in cycle 4.
  - mask=0: bist_end in cycle 1, pass=1.
- abort asserted in cycle 4 of a run_len=5 session:
  - IDLE in cycle 5, aborted=1, pass=0, no bist_end.
  - A following start clears aborted.
- Collisions:
  - start pulsed during RUN: ignored, timeline unchanged.
  - start and abort both high in IDLE: busy stays 0.
- reset asserted mid-RUN between clock edges:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a new start produces the nominal timeline.
